// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu : load/store unit, single outstanding req/gnt/rvalid memory transaction
//
// Accepts one load or store from the execute stage, validates the access
// against the decoder size/mask, places store data on the correct byte lanes,
// extracts and extends load data, and returns one response per accepted op.
//
// Ports
//   clock, reset_n          clock and asynchronous active-low reset
//   req_valid / req_ready   op handshake from execute (ready only when idle)
//   req_is_store            1 = store, 0 = load
//   req_addr, req_wdata     byte address and lane-0 justified store data
//   req_wbmask, req_size    decoder byte mask / access size
//   req_sign                sign-extend loads when set
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata, rsp_error    extended load data (held until next accept), error
//   mem_req/we/addr/wdata/wstrb   memory request channel, held until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata  memory grant and read return
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new op
// REQ   | mem_req asserted, waiting for mem_gnt (timeout counting)
// WAIT  | load granted, waiting for mem_rvalid (timeout counting)
// RESP  | rsp_valid pulse for one cycle
// ---------------------------------------------------------------------------
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wbmask,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Last counter value before the abort; the counter starts at 0 on the
    // first REQ cycle, so REQ+WAIT lasts exactly TIMEOUT_CYCLES cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic        store_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;

    logic        accept;
    logic        acc_err;
    logic [1:0]  req_off;
    logic        timeout_hit;
    logic [31:0] load_sh;
    logic [31:0] load_ext;

    assign req_off     = req_addr[1:0];
    assign accept      = req_valid && (state_q == S_IDLE);
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        acc_err = 1'b0;
        if (req_is_store) begin
            acc_err = (req_wbmask == 4'b0000)
                   || ((req_wbmask == 4'b0011) && req_off[0])
                   || ((req_wbmask == 4'b1111) && (req_off != 2'b00));
        end else begin
            acc_err = (req_size == 2'b11)
                   || ((req_size == 2'b01) && req_off[0])
                   || ((req_size == 2'b10) && (req_off != 2'b00));
        end
    end

    always_comb begin
        load_sh  = mem_rdata >> {off_q, 3'b000};
        load_ext = mem_rdata;
        case (size_q)
            2'b00:   load_ext = {{24{sign_q & load_sh[7]}},  load_sh[7:0]};
            2'b01:   load_ext = {{16{sign_q & load_sh[15]}}, load_sh[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant / read return take priority over a timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = acc_err ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    state_d = store_q ? S_RESP : S_WAIT;
                end else if (timeout_hit) begin
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (mem_rvalid || timeout_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= 8'd0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            sign_q      <= 1'b0;
            store_q     <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'b0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cnt_q      <= 8'd0;
                        off_q      <= req_off;
                        size_q     <= req_size;
                        sign_q     <= req_sign;
                        store_q    <= req_is_store;
                        err_q      <= acc_err;
                        rdata_q    <= 32'd0;
                        mem_addr_q <= {req_addr[31:2], 2'b00};
                        if (req_is_store && !acc_err) begin
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= req_wdata << {req_off, 3'b000};
                            mem_wstrb_q <= req_wbmask << req_off;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_wdata_q <= 32'd0;
                            mem_wstrb_q <= 4'b0000;
                        end
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (!mem_gnt && timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (mem_rvalid) begin
                        rdata_q <= load_ext;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign mem_req   = (state_q == S_REQ);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_error = (state_q == S_RESP) && err_q;
    assign rsp_rdata = rdata_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu : directed self-checking bench for lsu
// ---------------------------------------------------------------------------
module tb_lsu;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_wbmask = 4'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_sign = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    lsu #(.TIMEOUT_CYCLES(255)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wbmask   (req_wbmask),
        .req_size     (req_size),
        .req_sign     (req_sign),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        checks++;
        if ({req_ready, rsp_valid, rsp_error, rsp_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb}
            !== {1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0}) begin
            errors++;
            $display("FAIL reset_outputs: ready=%0b rv=%0b re=%0b rd=%h req=%0b we=%0b a=%h wd=%h ws=%b, required ready=1 all others 0",
                     req_ready, rsp_valid, rsp_error, rsp_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
        end
        #10;
        reset_n = 1'b1;
    endtask

    // Store with grant on the first REQ cycle; response expected at T+2.
    task automatic test_store(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wbmask, input logic [1:0] size,
                              input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                              input logic [3:0] exp_wstrb);
        @(posedge clock); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: got %0b required 1", name, req_ready);
        end
        req_valid = 1'b1; req_is_store = 1'b1; req_addr = addr; req_wdata = wdata;
        req_wbmask = wbmask; req_size = size; req_sign = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, rsp_valid}
            !== {1'b1, 1'b1, exp_addr, exp_wdata, exp_wstrb, 1'b0}) begin
            errors++;
            $display("FAIL %s_memreq: req=%0b we=%0b a=%h wd=%h ws=%b rv=%0b required req=1 we=1 a=%h wd=%h ws=%b rv=0",
                     name, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, rsp_valid, exp_addr, exp_wdata, exp_wstrb);
        end
        mem_gnt = 1'b1;
        @(posedge clock); #1;
        mem_gnt = 1'b0;
        checks++;
        if ({rsp_valid, rsp_error, rsp_rdata, mem_req} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL %s_rsp: rv=%0b re=%0b rd=%h req=%0b required rv=1 re=0 rd=0 req=0",
                     name, rsp_valid, rsp_error, rsp_rdata, mem_req);
        end
    endtask

    // Load with grant at T+1, rvalid at T+2; response expected at T+3.
    task automatic test_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                             input logic sign, input logic [31:0] rdata, input logic [31:0] exp);
        @(posedge clock); #1;
        req_valid = 1'b1; req_is_store = 1'b0; req_addr = addr; req_wdata = 32'hFFFF_FFFF;
        req_wbmask = 4'b0000; req_size = size; req_sign = sign;
        @(posedge clock); #1;
        req_valid = 1'b0;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wstrb} !== {1'b1, 1'b0, {addr[31:2], 2'b00}, 4'b0000}) begin
            errors++;
            $display("FAIL %s_memreq: req=%0b we=%0b a=%h ws=%b required req=1 we=0 a=%h ws=0000",
                     name, mem_req, mem_we, mem_addr, mem_wstrb, {addr[31:2], 2'b00});
        end
        mem_gnt = 1'b1;
        @(posedge clock); #1;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = rdata;
        checks++;
        if ({mem_req, rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL %s_wait: req=%0b rv=%0b required 0 0", name, mem_req, rsp_valid);
        end
        @(posedge clock); #1;
        mem_rvalid = 1'b0; mem_rdata = 32'hA5A5_A5A5;
        checks++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 1'b0, exp}) begin
            errors++;
            $display("FAIL %s_rsp: rv=%0b re=%0b rd=%h required rv=1 re=0 rd=%h",
                     name, rsp_valid, rsp_error, rsp_rdata, exp);
        end
    endtask

    // Illegal op: no memory access, error response at T+1.
    task automatic test_error(input string name, input logic is_store, input logic [31:0] addr,
                              input logic [3:0] wbmask, input logic [1:0] size);
        @(posedge clock); #1;
        req_valid = 1'b1; req_is_store = is_store; req_addr = addr; req_wdata = 32'h1234_5678;
        req_wbmask = wbmask; req_size = size; req_sign = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        checks++;
        if ({mem_req, rsp_valid, rsp_error, rsp_rdata} !== {1'b0, 1'b1, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL %s: req=%0b rv=%0b re=%0b rd=%h required req=0 rv=1 re=1 rd=0",
                     name, mem_req, rsp_valid, rsp_error, rsp_rdata);
        end
        @(posedge clock); #1;
        checks++;
        if ({mem_req, rsp_valid, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL %s_after: req=%0b rv=%0b ready=%0b required 0 0 1",
                     name, mem_req, rsp_valid, req_ready);
        end
    endtask

    // gnt and rvalid together in REQ: rvalid must be ignored, data comes from WAIT.
    task automatic test_gnt_rvalid_same();
        @(posedge clock); #1;
        req_valid = 1'b1; req_is_store = 1'b0; req_addr = 32'h0000_3000;
        req_size = 2'b10; req_sign = 1'b0; req_wbmask = 4'b0000;
        @(posedge clock); #1;
        req_valid = 1'b0;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        checks++;
        if ({mem_req, rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL gnt_rvalid_wait: req=%0b rv=%0b required 0 0", mem_req, rsp_valid);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(posedge clock); #1;
        mem_rvalid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            errors++;
            $display("FAIL gnt_rvalid_rsp: rv=%0b re=%0b rd=%h required 1 0 12345678",
                     rsp_valid, rsp_error, rsp_rdata);
        end
    endtask

    // A stray rvalid while idle must not produce a response.
    task automatic test_rvalid_idle();
        @(posedge clock); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        @(posedge clock); #1;
        mem_rvalid = 1'b0;
        checks++;
        if ({rsp_valid, req_ready, mem_req} !== 3'b010) begin
            errors++;
            $display("FAIL rvalid_idle: rv=%0b ready=%0b req=%0b required 0 1 0",
                     rsp_valid, req_ready, mem_req);
        end
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        @(posedge clock); #1;
        req_valid = 1'b1; req_is_store = 1'b0; req_addr = 32'h0000_4000;
        req_size = 2'b10; req_sign = 1'b0; req_wbmask = 4'b0000;
        @(posedge clock); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 255; i++) begin
            if (mem_req !== 1'b1 || rsp_valid !== 1'b0) bad++;
            @(posedge clock); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_req_held: %0d of 255 cycles without mem_req, required 0", bad);
        end
        checks++;
        if ({mem_req, rsp_valid, rsp_error, rsp_rdata} !== {1'b0, 1'b1, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL timeout_rsp: req=%0b rv=%0b re=%0b rd=%h required 0 1 1 0",
                     mem_req, rsp_valid, rsp_error, rsp_rdata);
        end
    endtask

    task automatic test_reset_mid_op();
        // Reset while in REQ: mem_req must fall without a clock edge.
        @(posedge clock); #1;
        req_valid = 1'b1; req_is_store = 1'b0; req_addr = 32'h0000_5000;
        req_size = 2'b10; req_sign = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, rsp_valid, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_in_req: req=%0b rv=%0b ready=%0b required 0 0 1",
                     mem_req, rsp_valid, req_ready);
        end
        @(negedge clock);
        reset_n = 1'b1;
        // Reset while in WAIT.
        @(posedge clock); #1;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        @(posedge clock); #1;
        mem_gnt = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, rsp_valid, rsp_rdata} !== {1'b0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset_in_wait: req=%0b rv=%0b rd=%h required 0 0 0",
                     mem_req, rsp_valid, rsp_rdata);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(posedge clock); #1;
        mem_rvalid = 1'b0;
        checks++;
        if ({rsp_valid, req_ready, rsp_rdata} !== {1'b0, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL reset_no_rsp: rv=%0b ready=%0b rd=%h required 0 1 0",
                     rsp_valid, req_ready, rsp_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_store("st_byte_off3", 32'h0000_1003, 32'h0000_00AB, 4'b0001, 2'b00,
                   32'h0000_1000, 32'hAB00_0000, 4'b1000);
        test_load("ld_byte_s", 32'h0000_2001, 2'b00, 1'b1, 32'h0000_8000, 32'hFFFF_FF80);
        test_load("ld_byte_u", 32'h0000_2001, 2'b00, 1'b0, 32'h0000_8000, 32'h0000_0080);
        test_load("ld_half_s", 32'h0000_2002, 2'b01, 1'b1, 32'h8001_1234, 32'hFFFF_8001);
        test_load("ld_half_u", 32'h0000_2002, 2'b01, 1'b0, 32'h8001_1234, 32'h0000_8001);
        test_load("ld_word", 32'h0000_3000, 2'b10, 1'b1, 32'h8765_4321, 32'h8765_4321);
        test_load("ld_byte3_s_pos", 32'h0000_3003, 2'b00, 1'b1, 32'h7F00_00FF, 32'h0000_007F);
        test_load("ld_half0_s_pos", 32'h0000_3000, 2'b01, 1'b1, 32'hFFFF_7FFF, 32'h0000_7FFF);
        test_error("err_ld_word_off2", 1'b0, 32'h0000_2002, 4'b0000, 2'b10);
        test_error("err_st_mask0", 1'b1, 32'h0000_2000, 4'b0000, 2'b00);
        test_error("err_ld_size3", 1'b0, 32'h0000_2000, 4'b0000, 2'b11);
        test_error("err_ld_half_off1", 1'b0, 32'h0000_2001, 4'b0000, 2'b01);
        test_error("err_st_half_off3", 1'b1, 32'h0000_2003, 4'b0011, 2'b01);
        test_error("err_st_word_off1", 1'b1, 32'h0000_2001, 4'b1111, 2'b10);
        test_store("st_half_off2", 32'h0000_6002, 32'h0000_BEEF, 4'b0011, 2'b01,
                   32'h0000_6000, 32'hBEEF_0000, 4'b1100);
        test_store("st_byte_off1", 32'h0000_0041, 32'h0000_00CD, 4'b0001, 2'b00,
                   32'h0000_0040, 32'h0000_CD00, 4'b0010);
        test_store("st_word_off0", 32'h0000_7000, 32'h0102_0304, 4'b1111, 2'b10,
                   32'h0000_7000, 32'h0102_0304, 4'b1111);
        test_gnt_rvalid_same();
        test_rvalid_idle();
        test_timeout();
        test_store("st_after_timeout", 32'h0000_8001, 32'h0000_0011, 4'b0001, 2'b00,
                   32'h0000_8000, 32'h0000_1100, 4'b0010);
        test_reset_mid_op();
        test_load("ld_after_reset", 32'h0000_9002, 2'b00, 1'b1, 32'h00FE_0000, 32'hFFFF_FFFE);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
